// File: rtl/topk_argmax.sv
// topk_argmax: streaming top-K selector over fp16 class scores.
// Accepts one score beat per cycle, keeps the K best {score, label} entries
// sorted descending, and presents them after the last beat of a frame until
// the consumer takes them. NaN beats are never ranked; they only raise nan_seen.
module topk_argmax #(
    parameter int NUM_C = 10,
    parameter int TOP_K = 3,
    localparam int LBL_W = $clog2(NUM_C),
    localparam int CNT_W = $clog2(TOP_K + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_score,
    input  logic [LBL_W-1:0]         in_label,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TOP_K*LBL_W-1:0]   out_labels,
    output logic [TOP_K*16-1:0]      out_scores,
    output logic [CNT_W-1:0]         out_count,
    output logic                     nan_seen
);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [15:0] NEG_INF = 16'hFC00;

    // fp16 NaN: all-ones exponent with a nonzero mantissa.
    function automatic logic is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

    // Map a non-NaN fp16 value to an unsigned key whose integer order is the
    // numeric order. -0 is folded onto +0 first so the two compare equal.
    function automatic logic [15:0] order_key(input logic [15:0] v);
        logic [15:0] m;
        m = (v == 16'h8000) ? 16'h0000 : v;
        if (m[15]) begin
            order_key = ~m;
        end else begin
            order_key = m | 16'h8000;
        end
    endfunction

    state_t                 state_r, state_nxt_s;
    logic                   in_ready_r, out_valid_r;
    logic [TOP_K-1:0]       occ_r, occ_nxt_s;
    logic [15:0]            score_r     [TOP_K];
    logic [15:0]            score_nxt_s [TOP_K];
    logic [LBL_W-1:0]       label_r     [TOP_K];
    logic [LBL_W-1:0]       label_nxt_s [TOP_K];
    logic [CNT_W-1:0]       count_r, count_nxt_s;
    logic                   nan_r, nan_nxt_s;

    logic                   beat_acc_s, beat_nan_s, ins_s, hs_s;
    logic [15:0]            new_key_s;
    logic [TOP_K-1:0]       gt_s, prev_gt_s;
    logic [TOP_K-1:0]       sh_occ_s;
    logic [15:0]            sh_score_s [TOP_K];
    logic [LBL_W-1:0]       sh_label_s [TOP_K];

    // Handshake decode and per-slot "new beat ranks above this slot" compare.
    always_comb begin
        beat_acc_s = in_valid && (state_r == ACC);
        hs_s       = out_ready && (state_r == DONE);
        beat_nan_s = is_nan(in_score);
        ins_s      = beat_acc_s && !beat_nan_s;
        new_key_s  = order_key(in_score);
        gt_s       = '0;
        prev_gt_s  = '0;
        sh_occ_s   = '0;
        for (int i = 0; i < TOP_K; i++) begin
            // Strictly greater keeps earlier arrivals ahead on ties.
            gt_s[i]       = !occ_r[i] || (new_key_s > order_key(score_r[i]));
            sh_score_s[i] = NEG_INF;
            sh_label_s[i] = '0;
        end
        for (int i = 1; i < TOP_K; i++) begin
            prev_gt_s[i]  = gt_s[i-1];
            sh_occ_s[i]   = occ_r[i-1];
            sh_score_s[i] = score_r[i-1];
            sh_label_s[i] = label_r[i-1];
        end
    end

    // Next slot contents: insert at the first slot the beat beats, shift the rest down.
    always_comb begin
        occ_nxt_s   = occ_r;
        score_nxt_s = score_r;
        label_nxt_s = label_r;
        count_nxt_s = count_r;
        nan_nxt_s   = nan_r;
        if (ins_s) begin
            for (int i = 0; i < TOP_K; i++) begin
                if (!gt_s[i]) begin
                    occ_nxt_s[i]   = occ_r[i];
                end else if (!prev_gt_s[i]) begin
                    occ_nxt_s[i]   = 1'b1;
                    score_nxt_s[i] = in_score;
                    label_nxt_s[i] = in_label;
                end else begin
                    occ_nxt_s[i]   = sh_occ_s[i];
                    score_nxt_s[i] = sh_score_s[i];
                    label_nxt_s[i] = sh_label_s[i];
                end
            end
            if (count_r != CNT_W'(TOP_K)) begin
                count_nxt_s = count_r + CNT_W'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
        if (beat_acc_s && beat_nan_s) begin
            nan_nxt_s = 1'b1;
        end else begin
            nan_nxt_s = nan_r;
        end
    end

    // FSM next state: last beat closes the frame, output handshake or clear reopens it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACC: begin
                if (beat_acc_s && in_last) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DONE: begin
                if (hs_s) begin
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = ACC;
        endcase
        if (clear) begin
            state_nxt_s = ACC;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACC;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACC);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Slot storage, count and NaN flag; reset, clear and result handoff all empty the slots.
    always_ff @(posedge clk) begin
        if (rst || clear || hs_s) begin
            occ_r   <= '0;
            count_r <= '0;
            nan_r   <= 1'b0;
            for (int i = 0; i < TOP_K; i++) begin
                score_r[i] <= NEG_INF;
                label_r[i] <= '0;
            end
        end else begin
            occ_r   <= occ_nxt_s;
            count_r <= count_nxt_s;
            nan_r   <= nan_nxt_s;
            for (int i = 0; i < TOP_K; i++) begin
                score_r[i] <= score_nxt_s[i];
                label_r[i] <= label_nxt_s[i];
            end
        end
    end

    // Flatten slot registers onto the output buses, slot 0 in the LSBs.
    always_comb begin
        out_labels = '0;
        out_scores = '0;
        for (int i = 0; i < TOP_K; i++) begin
            out_labels[i*LBL_W +: LBL_W] = label_r[i];
            out_scores[i*16 +: 16]       = score_r[i];
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_count = count_r;
    assign nan_seen  = nan_r;

endmodule

// File: tb/tb_topk_argmax.sv
// Directed and table-driven bench for topk_argmax (TOP_K=3) plus a TOP_K=1
// instance checked against a real-valued argmax model.
module tb_topk_argmax;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_last, out_ready;
    logic [15:0] in_score;
    logic [3:0]  in_label;

    logic        in_ready, out_valid, nan_seen;
    logic [11:0] out_labels;
    logic [47:0] out_scores;
    logic [1:0]  out_count;

    logic        in_ready1, out_valid1, nan_seen1;
    logic [3:0]  out_labels1;
    logic [15:0] out_scores1;
    logic [0:0]  out_count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    topk_argmax #(.NUM_C(10), .TOP_K(3)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
        .in_label(in_label), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_labels(out_labels), .out_scores(out_scores),
        .out_count(out_count), .nan_seen(nan_seen)
    );

    topk_argmax #(.NUM_C(10), .TOP_K(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_score(in_score),
        .in_label(in_label), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_labels(out_labels1), .out_scores(out_scores1),
        .out_count(out_count1), .nan_seen(nan_seen1)
    );

    typedef struct {
        int          n;
        logic [15:0] sc  [4];
        logic [3:0]  lb  [4];
        logic [15:0] esc [3];
        logic [3:0]  elb [3];
        int          ecnt;
        logic        enan;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [15:0] s, input logic [3:0] l, input logic last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_score  = s;
        in_label  = l;
        in_last   = last;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic take_result();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle();
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".count"},     64'(out_count), 64'd0);
        chk({tag, ".nan"},       64'(nan_seen),  64'd0);
        chk({tag, ".labels"},    64'(out_labels), 64'h000);
        chk({tag, ".scores"},    64'(out_scores), 64'hFC00_FC00_FC00);
    endtask

    // Numeric value of a non-NaN fp16 as a real number.
    function automatic real fp_val(input logic [15:0] v);
        int  e;
        real r;
        e = int'(v[14:10]);
        if (e == 31) begin
            r = 1.0e30;
        end else begin
            if (e == 0) begin
                r = real'(v[9:0]);
                e = 1;
            end else begin
                r = real'(1024 + int'(v[9:0]));
            end
            if (e >= 25) begin
                for (int k = 0; k < e - 25; k++) r = r * 2.0;
            end else begin
                for (int k = 0; k < 25 - e; k++) r = r / 2.0;
            end
        end
        if (v[15]) r = -r;
        return r;
    endfunction

    initial begin
        logic [11:0] el;
        logic [47:0] es;
        logic [15:0] rs [10];
        logic [15:0] s;
        logic [3:0]  best;
        logic [15:0] kept_s;
        logic [11:0] kept_l;

        vecs[0] = '{n:4, sc:'{16'h3800, 16'h4000, 16'hBC00, 16'h3C00}, lb:'{4'd0, 4'd1, 4'd2, 4'd3},
                    esc:'{16'h4000, 16'h3C00, 16'h3800}, elb:'{4'd1, 4'd3, 4'd0}, ecnt:3, enan:1'b0};
        vecs[1] = '{n:2, sc:'{16'h3C00, 16'h3C00, 16'h0000, 16'h0000}, lb:'{4'd4, 4'd2, 4'd0, 4'd0},
                    esc:'{16'h3C00, 16'h3C00, 16'hFC00}, elb:'{4'd4, 4'd2, 4'd0}, ecnt:2, enan:1'b0};
        vecs[2] = '{n:2, sc:'{16'h0000, 16'h8000, 16'h0000, 16'h0000}, lb:'{4'd0, 4'd1, 4'd0, 4'd0},
                    esc:'{16'h0000, 16'h8000, 16'hFC00}, elb:'{4'd0, 4'd1, 4'd0}, ecnt:2, enan:1'b0};
        vecs[3] = '{n:2, sc:'{16'h7E00, 16'h7C00, 16'h0000, 16'h0000}, lb:'{4'd0, 4'd5, 4'd0, 4'd0},
                    esc:'{16'h7C00, 16'hFC00, 16'hFC00}, elb:'{4'd5, 4'd0, 4'd0}, ecnt:1, enan:1'b1};
        vecs[4] = '{n:2, sc:'{16'h7E00, 16'hFC01, 16'h0000, 16'h0000}, lb:'{4'd3, 4'd2, 4'd0, 4'd0},
                    esc:'{16'hFC00, 16'hFC00, 16'hFC00}, elb:'{4'd0, 4'd0, 4'd0}, ecnt:0, enan:1'b1};
        vecs[5] = '{n:4, sc:'{16'hFC00, 16'h7BFF, 16'h7C00, 16'h0001}, lb:'{4'd6, 4'd7, 4'd8, 4'd9},
                    esc:'{16'h7C00, 16'h7BFF, 16'h0001}, elb:'{4'd8, 4'd7, 4'd9}, ecnt:3, enan:1'b0};
        vecs[6] = '{n:3, sc:'{16'hC000, 16'hBC00, 16'hC200, 16'h0000}, lb:'{4'd1, 4'd2, 4'd3, 4'd0},
                    esc:'{16'hBC00, 16'hC000, 16'hC200}, elb:'{4'd2, 4'd1, 4'd3}, ecnt:3, enan:1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_score = 16'h0000; in_label = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk_empty("reset");
        rst = 1'b0;

        // Table-driven frames.
        foreach (vecs[v]) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                drive_beat(vecs[v].sc[b], vecs[v].lb[b], (b == vecs[v].n - 1));
            end
            idle();
            for (int i = 0; i < 3; i++) begin
                el[i*4 +: 4]  = vecs[v].elb[i];
                es[i*16 +: 16] = vecs[v].esc[i];
            end
            chk($sformatf("vec%0d.out_valid", v), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d.in_ready", v),  64'(in_ready),  64'd0);
            chk($sformatf("vec%0d.labels", v),    64'(out_labels), 64'(el));
            chk($sformatf("vec%0d.scores", v),    64'(out_scores), 64'(es));
            chk($sformatf("vec%0d.count", v),     64'(out_count), 64'(vecs[v].ecnt));
            chk($sformatf("vec%0d.nan", v),       64'(nan_seen),  64'(vecs[v].enan));
            take_result();
            chk_empty($sformatf("vec%0d.after", v));
        end

        // Backpressure: hold the result with out_ready low while beats are offered.
        drive_beat(16'h4000, 4'd1, 1'b0);
        drive_beat(16'h3C00, 4'd6, 1'b1);
        idle();
        kept_l = {4'd0, 4'd6, 4'd1};
        kept_s = 16'h3C00;
        for (int c = 0; c < 5; c++) begin
            drive_beat(16'h7C00, 4'd9, 1'b1);
            chk($sformatf("bp%0d.out_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d.in_ready", c),  64'(in_ready),  64'd0);
            chk($sformatf("bp%0d.labels", c),    64'(out_labels), 64'(kept_l));
            chk($sformatf("bp%0d.scores", c),    64'(out_scores), {16'h0, 16'hFC00, kept_s, 16'h4000});
            chk($sformatf("bp%0d.count", c),     64'(out_count), 64'd2);
        end
        idle();
        chk("bp.hold_after_beat", 64'(out_labels), 64'(kept_l));
        take_result();
        chk_empty("bp.release");

        // Abort with clear after two beats; the beat offered with clear is dropped.
        drive_beat(16'h7C00, 4'd1, 1'b0);
        drive_beat(16'h7800, 4'd2, 1'b0);
        drive_beat(16'h7A00, 4'd3, 1'b1);
        clear = 1'b1;
        idle();
        chk_empty("clear");
        drive_beat(16'h4000, 4'd7, 1'b1);
        idle();
        chk("clr.frame.valid",  64'(out_valid), 64'd1);
        chk("clr.frame.labels", 64'(out_labels), 64'h007);
        chk("clr.frame.scores", 64'(out_scores), 64'hFC00_FC00_4000);
        chk("clr.frame.count",  64'(out_count), 64'd1);
        take_result();

        // Reset while holding a result.
        drive_beat(16'h7E00, 4'd2, 1'b0);
        drive_beat(16'h4400, 4'd3, 1'b1);
        idle();
        chk("rstdone.valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_empty("rstdone");
        rst = 1'b0;
        idle();
        chk_empty("rstdone.after");

        // TOP_K=1 instance against a real-valued argmax, earliest index wins ties.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 10; i++) begin
                if (f == 2) begin
                    case ($urandom_range(0, 3))
                        0:       s = 16'h3C00;
                        1:       s = 16'h0000;
                        2:       s = 16'h8000;
                        default: s = 16'hBC00;
                    endcase
                end else begin
                    s = 16'($urandom);
                    if (s[14:10] == 5'h1F) s[9:0] = 10'h000;
                end
                rs[i] = s;
            end
            if (f == 1) rs[8] = rs[2];
            best = 4'd0;
            for (int i = 1; i < 10; i++) begin
                if (fp_val(rs[i]) > fp_val(rs[best])) best = 4'(i);
            end
            for (int i = 0; i < 10; i++) begin
                drive_beat(rs[i], 4'(i), (i == 9));
            end
            idle();
            chk($sformatf("k1.f%0d.valid", f), 64'(out_valid1), 64'd1);
            chk($sformatf("k1.f%0d.label", f), 64'(out_labels1), 64'(best));
            chk($sformatf("k1.f%0d.score", f), 64'(out_scores1), 64'(rs[best]));
            chk($sformatf("k1.f%0d.count", f), 64'(out_count1), 64'd1);
            take_result();
            chk($sformatf("k1.f%0d.cleared", f), 64'(out_scores1), 64'hFC00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/topk_argmax.md
TOPK_ARGMAX -- requirements
Module: topk_argmax

Interface
REQ-001 SHALL have parameter NUM_C, default 10, meaning number of classes; label width LBL_W = $clog2(NUM_C).
REQ-002 SHALL have parameter TOP_K, default 3, meaning number of best entries tracked; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1 bit: the score beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-008 SHALL have port in_score, input, 16 bits: IEEE fp16 class score.
REQ-009 SHALL have port in_label, input, LBL_W bits: class index of the beat.
REQ-010 SHALL have port in_last, input, 1 bit: final beat of the frame.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_labels, output, TOP_K*LBL_W bits: labels, slot 0 (best) in the LSBs.
REQ-014 SHALL have port out_scores, output, TOP_K*16 bits: scores, in the same slot order.
REQ-015 SHALL have port out_count, output, $clog2(TOP_K+1) bits: number of occupied slots.
REQ-016 SHALL have port nan_seen, output, 1 bit: the frame contained at least one NaN.

Function
REQ-017 SHALL implement FSM states ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-018 SHALL treat a beat as accepted only when in_valid and in_ready are both high on a clk edge.
REQ-019 SHALL keep TOP_K slots, each holding {occ, score, label}, ordered descending by score, and SHALL process one accepted beat per cycle with no stall in ACC.
REQ-020 SHALL compare fp16 values by numeric order: -0 equals +0; -inf is below all finite values; +inf is above all finite values.
REQ-021 SHALL insert a non-NaN beat at the first slot that is unoccupied or has a strictly lower score, shift lower slots down by one, and drop the old last slot.
REQ-022 SHALL, on equal scores, keep the earlier arrival ahead of the new beat (stable ordering).
REQ-023 SHALL not insert a NaN beat (exponent 0x1F with nonzero mantissa), and SHALL set nan_seen when one is accepted.
REQ-024 SHALL increment out_count on each insert, saturating at TOP_K.
REQ-025 SHALL move ACC->DONE on the edge that accepts the in_last beat, including the effect of that beat, so the result is visible one cycle after the last beat.
REQ-026 SHALL hold out_* stable in DONE until out_valid and out_ready are both high on an edge.
REQ-027 SHALL, on that out handshake edge, clear all slots (occ=0, score=0xFC00, label=0), out_count and nan_seen, and go to ACC.
REQ-028 SHALL, when clear=1, perform the REQ-027 clear and go to ACC from any state, ignoring any beat or handshake in that cycle; rst has priority over clear.
REQ-029 SHALL drive unoccupied slots as score 0xFC00 and label 0.
REQ-030 SHALL, for a frame of only NaNs, enter DONE with out_count=0 and nan_seen=1.
REQ-031 SHALL treat a frame with more than NUM_C beats or repeated labels as legal, with no checking.

Reset
REQ-032 SHALL, while rst=1, enter ACC with out_valid=0, in_ready=1, out_count=0, nan_seen=0, all slot scores 0xFC00, all slot labels 0 and all occ bits 0.
REQ-033 SHALL let rst asserted mid-frame or in DONE discard all partial results, with no output pulse.

Verification
REQ-034 SHALL test, with TOP_K=3: scores 0x3800/L0, 0x4000/L1, 0xBC00/L2, 0x3C00/L3(last) -> DONE next cycle; labels {1,3,0}; scores {0x4000,0x3C00,0x3800}; count 3.
REQ-035 SHALL test a tie: 0x3C00/L4 then 0x3C00/L2(last) -> slot0=L4, slot1=L2; and -0 (0x8000)/L1 after +0/L0 -> L0 stays ahead.
REQ-036 SHALL test NaN: 0x7E00/L0, 0x7C00/L5(last) -> count 1, slot0=L5 score 0x7C00, nan_seen=1; an all-NaN frame -> count 0.
REQ-037 SHALL test backpressure: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid beats ignored; out_ready=1 -> ACC with cleared slots next cycle.
REQ-038 SHALL test aborts: clear after 2 beats, then a 1-beat frame 0x4000/L7 -> only L7 reported; rst in DONE -> REQ-032 values on the next cycle.
REQ-039 SHALL test TOP_K=1, NUM_C=10 with 10 random scores -> matches a reference argmax with the earliest index winning on ties.
